// File: rtl/yarvi_trace_ctrl.sv
// yarvi_trace_ctrl
// Sequences the instruction-trace path between core writeback and the disassembler.
// Retired instructions are captured inside a window opened by a PC trigger and closed
// after a configurable number of records. Captured records are buffered in a FIFO and
// drained one per accepted handshake.
//
// Ports
//   clock, reset                    rising-edge clock, asynchronous active-high reset
//   retire_valid/prv/pc/insn/rd/val retired instruction from the core
//   cfg_arm, cfg_stop               control pulses (stop wins when both are high)
//   cfg_trig_any, cfg_trig_pc       trigger select: any retire, or a retire at cfg_trig_pc
//   cfg_window                      records per window, 0 = unlimited
//   cfg_prv_mask                    per-privilege visibility (only with YARVI_TRACE_FILTER_EN)
//   dis_ready / dis_valid           drain handshake for the head record
//   dis_info                        [3] gap before record, [2] first, [1] last, [0] rd != 0
//   dis_prv/pc/insn/wb_rd/wb_val    head record payload (zero while the FIFO is empty)
//   state                           0 IDLE, 1 ARMED, 2 TRACING, 3 DONE
//   drop_cnt                        records lost to a full FIFO, saturating
//
// Build option: define YARVI_TRACE_FILTER_EN to add cfg_prv_mask. A retire whose
// privilege bit is clear in the mask is ignored completely.

`timescale 1ns/1ps

`ifndef VMSB
`define VMSB 31
`endif

module yarvi_trace_ctrl #(
    parameter int DEPTH_LOG2 = 3,
    parameter int CNT_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               retire_valid,
    input  logic [1:0]         retire_prv,
    input  logic [`VMSB:0]     retire_pc,
    input  logic [31:0]        retire_insn,
    input  logic [4:0]         retire_rd,
    input  logic [`VMSB:0]     retire_val,
    input  logic               cfg_arm,
    input  logic               cfg_stop,
    input  logic               cfg_trig_any,
    input  logic [`VMSB:0]     cfg_trig_pc,
    input  logic [CNT_W-1:0]   cfg_window,
`ifdef YARVI_TRACE_FILTER_EN
    input  logic [3:0]         cfg_prv_mask,
`endif
    input  logic               dis_ready,
    output logic               dis_valid,
    output logic [3:0]         dis_info,
    output logic [1:0]         dis_prv,
    output logic [`VMSB:0]     dis_pc,
    output logic [31:0]        dis_insn,
    output logic [4:0]         dis_wb_rd,
    output logic [`VMSB:0]     dis_wb_val,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   drop_cnt
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_TRACING = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]     info;
        logic [1:0]     prv;
        logic [`VMSB:0] pc;
        logic [31:0]    insn;
        logic [4:0]     rd;
        logic [`VMSB:0] val;
    } rec_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               gap_q, gap_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    rec_t               mem_q [DEPTH];

    logic               visible;
    logic               hit;
    logic               capture;
    logic               is_first;
    logic               is_last;
    logic [CNT_W-1:0]   count_inc;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;
    rec_t               wr_rec;
    rec_t               head;

`ifdef YARVI_TRACE_FILTER_EN
    assign visible = retire_valid & cfg_prv_mask[retire_prv];
`else
    assign visible = retire_valid;
`endif

    assign hit = cfg_trig_any | (retire_pc == cfg_trig_pc);

    // The window counter saturates so unlimited mode never wraps back to a small value.
    // Using >= keeps the window closing even if cfg_window is lowered mid-trace.
    assign count_inc = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1);
    assign is_last   = (cfg_window != '0) && (count_inc >= cfg_window);

    // Capture decision and trace FSM next state. Cycles carrying a control pulse never
    // capture, so arm/stop take effect cleanly before any new record is taken.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        is_first = 1'b0;
        if (visible && !cfg_arm && !cfg_stop) begin
            if (state_q == S_TRACING) begin
                capture = 1'b1;
            end else if (state_q == S_ARMED && hit) begin
                capture  = 1'b1;
                is_first = 1'b1;
            end
        end
        if (cfg_stop) begin
            state_d = S_DONE;
        end else if (cfg_arm) begin
            state_d = S_ARMED;
        end else if (capture) begin
            state_d = is_last ? S_DONE : S_TRACING;
        end
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign pop   = !empty && dis_ready;
    assign push  = capture && (!full || pop);
    assign drop  = capture && full && !pop;

    assign wr_rec.info = {gap_q, is_first, is_last, (retire_rd != 5'd0)};
    assign wr_rec.prv  = retire_prv;
    assign wr_rec.pc   = retire_pc;
    assign wr_rec.insn = retire_insn;
    assign wr_rec.rd   = retire_rd;
    assign wr_rec.val  = retire_val;

    // Window count, drop counter and the pending-gap flag that marks the next stored record.
    always_comb begin
        count_d = count_q;
        drop_d  = drop_q;
        gap_d   = gap_q;
        if (cfg_arm) begin
            count_d = '0;
        end else if (capture) begin
            count_d = count_inc;
        end
        if (drop) begin
            gap_d = 1'b1;
            if (drop_q != {CNT_W{1'b1}}) begin
                drop_d = drop_q + CNT_W'(1);
            end
        end else if (push) begin
            gap_d = 1'b0;
        end
    end

    // Control state registers, all cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            drop_q   <= '0;
            gap_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            gap_q   <= gap_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Record storage needs no reset; the pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-2:0]] <= wr_rec;
        end
    end

    // The payload is forced to zero while empty so stale entries never reach the sink.
    assign dis_valid  = !empty;
    assign head       = dis_valid ? mem_q[rd_ptr_q[PTR_W-2:0]] : '0;
    assign dis_info   = head.info;
    assign dis_prv    = head.prv;
    assign dis_pc     = head.pc;
    assign dis_insn   = head.insn;
    assign dis_wb_rd  = head.rd;
    assign dis_wb_val = head.val;
    assign state      = state_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_yarvi_trace_ctrl.sv
// tb_yarvi_trace_ctrl
// Self-checking bench for yarvi_trace_ctrl. A queue-based reference model tracks the
// expected FIFO contents, FSM state and drop count; every cycle the DUT outputs are
// compared against it at the falling edge. Directed scenarios add literal expectations,
// then a long randomized phase exercises arm/stop/window/backpressure interactions.

`timescale 1ns/1ps

`ifndef VMSB
`define VMSB 31
`endif

module tb_yarvi_trace_ctrl;

    localparam int DEPTH   = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = 65535;

    logic               clock;
    logic               reset;
    logic               retireValid;
    logic [1:0]         retirePrv;
    logic [`VMSB:0]     retirePc;
    logic [31:0]        retireInsn;
    logic [4:0]         retireRd;
    logic [`VMSB:0]     retireVal;
    logic               cfgArm;
    logic               cfgStop;
    logic               cfgTrigAny;
    logic [`VMSB:0]     cfgTrigPc;
    logic [CNT_W-1:0]   cfgWindow;
`ifdef YARVI_TRACE_FILTER_EN
    logic [3:0]         cfgPrvMask;
`endif
    logic               disReady;
    logic               disValid;
    logic [3:0]         disInfo;
    logic [1:0]         disPrv;
    logic [`VMSB:0]     disPc;
    logic [31:0]        disInsn;
    logic [4:0]         disWbRd;
    logic [`VMSB:0]     disWbVal;
    logic [1:0]         dutState;
    logic [CNT_W-1:0]   dropCnt;

    typedef struct {
        logic [3:0]     info;
        logic [1:0]     prv;
        logic [`VMSB:0] pc;
        logic [31:0]    insn;
        logic [4:0]     rd;
        logic [`VMSB:0] val;
    } rec_t;

    rec_t modelQ[$];
    int   mState;
    int   mCount;
    int   mDrop;
    bit   mGap;
    int   nChecks;
    int   nFails;

    yarvi_trace_ctrl #(.DEPTH_LOG2(3), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .retire_valid (retireValid),
        .retire_prv   (retirePrv),
        .retire_pc    (retirePc),
        .retire_insn  (retireInsn),
        .retire_rd    (retireRd),
        .retire_val   (retireVal),
        .cfg_arm      (cfgArm),
        .cfg_stop     (cfgStop),
        .cfg_trig_any (cfgTrigAny),
        .cfg_trig_pc  (cfgTrigPc),
        .cfg_window   (cfgWindow),
`ifdef YARVI_TRACE_FILTER_EN
        .cfg_prv_mask (cfgPrvMask),
`endif
        .dis_ready    (disReady),
        .dis_valid    (disValid),
        .dis_info     (disInfo),
        .dis_prv      (disPrv),
        .dis_pc       (disPc),
        .dis_insn     (disInsn),
        .dis_wb_rd    (disWbRd),
        .dis_wb_val   (disWbVal),
        .state        (dutState),
        .drop_cnt     (dropCnt)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        mState = 0;
        mCount = 0;
        mDrop  = 0;
        mGap   = 1'b0;
    endtask

    // Reference behaviour for one clock edge, using the inputs currently applied.
    task automatic modelStep();
        bit   visible;
        bit   hit;
        bit   capture;
        bit   first;
        bit   last;
        int   newCount;
        rec_t r;
        visible = retireValid;
`ifdef YARVI_TRACE_FILTER_EN
        visible = visible && cfgPrvMask[retirePrv];
`endif
        hit      = cfgTrigAny || (retirePc == cfgTrigPc);
        capture  = visible && !cfgArm && !cfgStop && (mState == 2 || (mState == 1 && hit));
        first    = (mState == 1);
        newCount = (mCount < CNT_MAX) ? mCount + 1 : CNT_MAX;
        last     = (cfgWindow != 0) && (newCount >= int'(cfgWindow));
        if (modelQ.size() != 0 && disReady) begin
            void'(modelQ.pop_front());
        end
        if (capture) begin
            if (modelQ.size() < DEPTH) begin
                r.info = {mGap, first, last, (retireRd != 0)};
                r.prv  = retirePrv;
                r.pc   = retirePc;
                r.insn = retireInsn;
                r.rd   = retireRd;
                r.val  = retireVal;
                modelQ.push_back(r);
                mGap = 1'b0;
            end else begin
                if (mDrop < CNT_MAX) mDrop++;
                mGap = 1'b1;
            end
        end
        if (cfgArm) mCount = 0;
        else if (capture) mCount = newCount;
        if (cfgStop) mState = 3;
        else if (cfgArm) mState = 1;
        else if (capture) mState = last ? 3 : 2;
    endtask

    task automatic checkOutput();
        check("dis_valid", 64'(disValid), 64'(modelQ.size() != 0));
        check("state", 64'(dutState), 64'(mState));
        check("drop_cnt", 64'(dropCnt), 64'(mDrop));
        if (modelQ.size() != 0) begin
            check("dis_info", 64'(disInfo), 64'(modelQ[0].info));
            check("dis_prv", 64'(disPrv), 64'(modelQ[0].prv));
            check("dis_pc", 64'(disPc), 64'(modelQ[0].pc));
            check("dis_insn", 64'(disInsn), 64'(modelQ[0].insn));
            check("dis_wb_rd", 64'(disWbRd), 64'(modelQ[0].rd));
            check("dis_wb_val", 64'(disWbVal), 64'(modelQ[0].val));
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] prv, input logic [`VMSB:0] pc,
                                 input logic [4:0] rd, input logic [`VMSB:0] val);
        retireValid = valid;
        retirePrv   = prv;
        retirePc    = pc;
        retireInsn  = 32'(pc) ^ 32'h0000_0013;
        retireRd    = rd;
        retireVal   = val;
    endtask

    // One clock edge: advance the model, then compare at the following falling edge.
    task automatic cycle();
        modelStep();
        @(posedge clock);
        @(negedge clock);
        checkOutput();
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 2'd0, '0, 5'd0, '0);
        cfgArm  = 1'b0;
        cfgStop = 1'b0;
    endtask

    task automatic pulseArm();
        idleInputs();
        cfgArm = 1'b1;
        cycle();
        cfgArm = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        modelReset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        checkOutput();
    endtask

    logic [`VMSB:0] expPc   [3];
    logic [3:0]     expInfo [3];

    initial begin
        nChecks = 0;
        nFails  = 0;
        reset   = 1'b0;
        idleInputs();
        cfgTrigAny = 1'b0;
        cfgTrigPc  = '0;
        cfgWindow  = '0;
        disReady   = 1'b0;
`ifdef YARVI_TRACE_FILTER_EN
        cfgPrvMask = 4'hF;
`endif
        #1;
        doReset();
        check("reset state", 64'(dutState), 64'd0);
        check("reset dis_valid", 64'(disValid), 64'd0);
        check("reset drop_cnt", 64'(dropCnt), 64'd0);
        check("reset dis_pc", 64'(disPc), 64'd0);

        // Scenario 1: PC trigger at 0x100 with a three-record window.
        $display("[TB] window trigger scenario");
        cfgTrigPc = 'h100;
        cfgWindow = 16'd3;
        pulseArm();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 2'd3, `VMSB'(32'hFC + 4 * i), 5'd1, `VMSB'(i));
            cycle();
        end
        idleInputs();
        check("window ends DONE", 64'(dutState), 64'd3);
        expPc[0] = 'h100; expInfo[0] = 4'b0101;
        expPc[1] = 'h104; expInfo[1] = 4'b0001;
        expPc[2] = 'h108; expInfo[2] = 4'b0011;
        disReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("window rec pc", 64'(disPc), 64'(expPc[i]));
            check("window rec info", 64'(disInfo), 64'(expInfo[i]));
            cycle();
        end
        check("0x10C not captured", 64'(disValid), 64'd0);

        // Scenarios 2 and 3: overflow, then pop and push in the same cycle while full.
        $display("[TB] overflow scenario");
        disReady   = 1'b0;
        cfgTrigAny = 1'b1;
        cfgWindow  = 16'd0;
        pulseArm();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 2'd0, `VMSB'(32'h200 + 4 * i), 5'(i), `VMSB'(100 + i));
            cycle();
        end
        check("overflow drop_cnt", 64'(dropCnt), 64'd2);
        check("overflow head pc", 64'(disPc), 64'h200);
        disReady = 1'b1;
        applyStimulus(1'b1, 2'd0, 'h300, 5'd9, 'h55);
        cycle();
        idleInputs();
        check("full pop+push drop_cnt", 64'(dropCnt), 64'd2);
        for (int i = 0; i < 8; i++) begin
            check("drain order pc", 64'(disPc), (i < 7) ? 64'(32'h204 + 4 * i) : 64'h300);
            if (i == 7) check("gap flag", 64'(disInfo[3]), 64'd1);
            cycle();
        end

        // Scenario 4: single push into an empty FIFO shows up one cycle later.
        $display("[TB] latency scenario");
        disReady = 1'b0;
        check("empty before push", 64'(disValid), 64'd0);
        applyStimulus(1'b1, 2'd1, 'h500, 5'd5, 'h2A);
        cycle();
        check("latency dis_valid", 64'(disValid), 64'd1);
        check("latency info rd", 64'(disInfo[0]), 64'd1);
        check("latency wb_val", 64'(disWbVal), 64'h2A);
        disReady = 1'b1;
        applyStimulus(1'b1, 2'd1, 'h504, 5'd0, 'h7);
        cycle();
        check("rd0 info", 64'(disInfo[0]), 64'd0);
        idleInputs();
        cycle();

        // Scenario 5: stop beats arm, then an asynchronous reset mid-drain.
        $display("[TB] stop/reset scenario");
        cfgArm  = 1'b1;
        cfgStop = 1'b1;
        cycle();
        check("stop wins", 64'(dutState), 64'd3);
        disReady = 1'b0;
        pulseArm();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'd2, `VMSB'(32'h600 + 4 * i), 5'd3, `VMSB'(i));
            cycle();
        end
        idleInputs();
        disReady = 1'b1;
        cycle();
        #2;
        reset = 1'b1;
        #1;
        check("async reset dis_valid", 64'(disValid), 64'd0);
        check("async reset state", 64'(dutState), 64'd0);
        modelReset();
        @(negedge clock);
        reset = 1'b0;
        checkOutput();

`ifdef YARVI_TRACE_FILTER_EN
        // Scenario 6: privilege filter keeps only machine-mode retires.
        $display("[TB] privilege filter scenario");
        disReady   = 1'b0;
        cfgPrvMask = 4'b1000;
        cfgTrigAny = 1'b1;
        cfgWindow  = 16'd0;
        pulseArm();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, (i % 2 == 0) ? 2'd0 : 2'd3, `VMSB'(32'h400 + 4 * i), 5'd1, '0);
            cycle();
        end
        idleInputs();
        disReady = 1'b1;
        check("filter first pc", 64'(disPc), 64'h404);
        cycle();
        check("filter second pc", 64'(disPc), 64'h40C);
        cycle();
        check("filter only two", 64'(disValid), 64'd0);
        cfgPrvMask = 4'hF;
`endif

        // Randomized phase: every cycle checked against the reference model.
        $display("[TB] random phase");
        cfgTrigPc  = 'h108;
        cfgTrigAny = 1'b0;
        cfgWindow  = 16'd4;
        for (int n = 0; n < 4000; n++) begin
            int readyPct;
            readyPct = ((n / 250) % 3 == 0) ? 20 : (((n / 250) % 3 == 1) ? 50 : 90);
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          `VMSB'(32'h100 + 4 * $urandom_range(0, 7)),
                          5'($urandom_range(0, 31)), `VMSB'($urandom));
            retireInsn = $urandom;
            cfgArm   = ($urandom_range(0, 39) == 0);
            cfgStop  = ($urandom_range(0, 89) == 0);
            disReady = ($urandom_range(0, 99) < readyPct);
            if ($urandom_range(0, 49) == 0) begin
                cfgWindow  = 16'($urandom_range(0, 6));
                cfgTrigAny = ($urandom_range(0, 3) == 0);
            end
`ifdef YARVI_TRACE_FILTER_EN
            if ($urandom_range(0, 99) == 0) cfgPrvMask = 4'($urandom_range(0, 15));
`endif
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
